// File: rtl/uart_rx_oversampled_if.sv
// Downstream word interface of the oversampled UART receiver: received word, sticky status, clear.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversampled_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] d_out;
  logic            rx_done;
  logic            frame_err;
  logic            overrun_err;
  logic            rx_clr;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    input  rx_clr,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output d_out, rx_done, frame_err, overrun_err
  );

  modport slave (
    output rx_clr,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  d_out, rx_done, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver sampling at bit centres from an OVS-times-baud tick; sticky done/error flags.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY_ODD parameter and parity_err.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  input  logic rx,
  output logic busy,
  uart_rx_oversampled_if.master bus
);

  localparam int S_MAX = (SB_TICK > OVS) ? SB_TICK : OVS;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = $clog2(DBIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            rx_meta;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      s               <= '0;
      n               <= '0;
      shreg           <= '0;
      bus.d_out       <= '0;
      bus.rx_done     <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err  <= 1'b0;
      par_bit         <= 1'b0;
`endif
    end else begin
      // NOTE: rx_clr is applied first so a completion set later in this block wins the same cycle.
      if (bus.rx_clr) begin
        bus.rx_done     <= 1'b0;
        bus.frame_err   <= 1'b0;
        bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        bus.parity_err  <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == SW'(OVS / 2 - 1)) begin
              s     <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == SW'(OVS - 1)) begin
              s     <= '0;
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == SW'(OVS - 1)) begin
              s       <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              s <= '0;
              if (rx_s) begin
                bus.d_out   <= shreg;
                bus.rx_done <= 1'b1;
                if (bus.rx_done && !bus.rx_clr) bus.overrun_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if ((^shreg ^ par_bit) != PARITY_ODD) bus.parity_err <= 1'b1;
`endif
                state <= IDLE;
              end else begin
                bus.frame_err <= 1'b1;
                state         <= BREAK;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        // A held-low line must return high before a new start bit is accepted.
        BREAK: begin
          if (s_tick && rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
